// File: rtl/rr_dispatch_8.sv
// Round-robin stream dispatcher: input FIFO feeding a registered select/data
// output stage that drives an 8-way demux, with one-hot lane valids.
module rr_dispatch_8 #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [DATA_WIDTH-1:0]            data_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic [7:0]                       lane_ready_i,
    output logic [2:0]                       select_o,
    output logic [DATA_WIDTH-1:0]            data_o,
    output logic [7:0]                       lane_valid_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  count_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        ST_EMPTY,
        ST_HOLD
    } state_t;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;

    state_t                state_q, state_d;
    logic [2:0]            sel_q, sel_d;
    logic [2:0]            ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic                  push, pop, fire, load, found;
    logic [2:0]            pick_lane, scan_idx;

    // ready_o depends only on occupancy and reset, never on this cycle's inputs
    assign ready_o = !rst_i && (count_q < CW'(FIFO_DEPTH));
    assign push    = valid_i && ready_o;
    assign fire    = (state_q == ST_HOLD) && lane_ready_i[sel_q];
    assign load    = ((state_q == ST_EMPTY) || fire) && (count_q != '0) && (|lane_ready_i);
    assign pop     = load;

    always_comb begin
        found     = 1'b0;
        pick_lane = '0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            scan_idx = ptr_q + 3'(i);
            if (!found && lane_ready_i[scan_idx]) begin
                found     = 1'b1;
                pick_lane = scan_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        if (load) begin
            state_d = ST_HOLD;
            sel_d   = pick_lane;
            data_d  = mem_q[rd_ptr_q];
            ptr_d   = pick_lane + 3'd1;
        end else if (fire) begin
            state_d = ST_EMPTY;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_EMPTY;
            sel_q    <= '0;
            data_q   <= '0;
            ptr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Storage needs no reset: occupancy gates every read
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

    assign select_o     = sel_q;
    assign data_o       = data_q;
    assign lane_valid_o = (state_q == ST_HOLD) ? (8'd1 << sel_q) : '0;
    assign count_o      = count_q;

endmodule

// File: tb/tb_rr_dispatch_8.sv
// Scoreboard bench for rr_dispatch_8: directed words with hand-computed lanes,
// a driver process for the input stream and a monitor checking each fire.
module tb_rr_dispatch_8;

    typedef struct {
        logic [2:0] lane;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] data_i = '0;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic [7:0] lane_ready_i = '0;
    logic [2:0] select_o;
    logic [7:0] data_o;
    logic [7:0] lane_valid_o;
    logic [2:0] count_o;

    int   tests = 0;
    int   fails = 0;
    logic acc = 1'b0;
    logic [7:0] txq [$];
    exp_t       expq [$];

    rr_dispatch_8 #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .lane_ready_i (lane_ready_i),
        .select_o     (select_o),
        .data_o       (data_o),
        .lane_valid_o (lane_valid_o),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [2:0] lane, input bit expect_it);
        exp_t e;
        txq.push_back(d);
        if (expect_it) begin
            e.lane = lane;
            e.data = d;
            expq.push_back(e);
        end
    endtask

    // Input driver: holds valid with the queue head until the handshake lands
    initial begin
        forever begin
            @(negedge clk);
            acc = valid_i && ready_o && !rst_i;
            @(posedge clk);
            #2;
            if (acc && txq.size() > 0) void'(txq.pop_front());
            if (txq.size() > 0) begin
                valid_i = 1'b1;
                data_i  = txq[0];
            end else begin
                valid_i = 1'b0;
            end
        end
    end

    // Monitor: a fire is a held word whose lane is ready going into the next edge
    always @(negedge clk) begin
        if (!rst_i && lane_valid_o != 8'h00) begin
            chk("onehot", 32'(lane_valid_o), 32'(8'd1 << select_o));
            if ((lane_valid_o & lane_ready_i) != 8'h00) begin
                if (expq.size() == 0) begin
                    chk("unexpected_fire", 32'(data_o), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("fire_lane", 32'(select_o), 32'(e.lane));
                    chk("fire_data", 32'(data_o), 32'(e.data));
                end
            end
        end
    end

    task automatic do_reset();
        rst_i = 1'b1;
        txq.delete();
        expq.delete();
        #2;
        chk("rst_ready", 32'(ready_o), 0);
        chk("rst_count", 32'(count_o), 0);
        chk("rst_lvalid", 32'(lane_valid_o), 0);
        chk("rst_sel", 32'(select_o), 0);
        chk("rst_data", 32'(data_o), 0);
        sync();
        sync();
        rst_i = 1'b0;
        sync();
        chk("post_rst_ready", 32'(ready_o), 1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((expq.size() != 0 || txq.size() != 0) && n < 300) begin
            sync();
            n++;
        end
        chk({name, "_drain_timeout"}, 32'(n < 300), 1);
        chk({name, "_end_count"}, 32'(count_o), 0);
        chk({name, "_end_lvalid"}, 32'(lane_valid_o), 0);
    endtask

    task automatic wait_lvalid(input logic [7:0] want, input string name);
        int n = 0;
        while (lane_valid_o !== want && n < 20) begin
            sync();
            n++;
        end
        chk(name, 32'(lane_valid_o), 32'(want));
    endtask

    initial begin
        // All lanes ready, 8 words: lanes 0..7 in order, 1-cycle latency
        do_reset();
        lane_ready_i = 8'hFF;
        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 3'(i), 1'b1);
        sync();
        chk("t1_lat_edge_k", 32'(lane_valid_o), 0);
        sync();
        chk("t1_lat_edge_k1", 32'(lane_valid_o), 32'h01);
        drain("t1");

        // Only lanes 2 and 5 ready
        do_reset();
        lane_ready_i = 8'b0010_0100;
        send(8'hA0, 3'd2, 1'b1);
        send(8'hA1, 3'd5, 1'b1);
        send(8'hA2, 3'd2, 1'b1);
        send(8'hA3, 3'd5, 1'b1);
        drain("t2");

        // Word held on lane 3 while its consumer stalls; FIFO backs up
        do_reset();
        lane_ready_i = 8'h08;
        send(8'h30, 3'd3, 1'b1);
        wait_lvalid(8'h08, "t3_hold_start");
        lane_ready_i = 8'hF7;
        send(8'h31, 3'd4, 1'b1);
        send(8'h32, 3'd5, 1'b1);
        send(8'h33, 3'd6, 1'b1);
        send(8'h34, 3'd7, 1'b1);
        send(8'h35, 3'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            sync();
            chk("t3_sel_stable", 32'(select_o), 3);
            chk("t3_data_stable", 32'(data_o), 32'h30);
            chk("t3_lvalid_stable", 32'(lane_valid_o), 32'h08);
        end
        chk("t3_full_count", 32'(count_o), 4);
        chk("t3_full_ready", 32'(ready_o), 0);
        lane_ready_i = 8'hFF;
        drain("t3");

        // No lane ready: FIFO fills, nothing presented
        do_reset();
        lane_ready_i = 8'h00;
        for (int i = 0; i < 5; i++) send(8'h40 + 8'(i), 3'(i), 1'b1);
        repeat (10) sync();
        chk("t4_count", 32'(count_o), 4);
        chk("t4_ready", 32'(ready_o), 0);
        chk("t4_lvalid", 32'(lane_valid_o), 0);
        lane_ready_i = 8'hFF;
        sync();
        chk("t4_ready_after_pop", 32'(ready_o), 1);
        chk("t4_count_after_pop", 32'(count_o), 3);
        drain("t4");

        // Full-rate streaming for 100 words
        do_reset();
        lane_ready_i = 8'hFF;
        for (int i = 0; i < 100; i++) send(8'(i + 1), 3'(i % 8), 1'b1);
        repeat (4) sync();
        for (int i = 0; i < 85; i++) begin
            chk("t5_count_const", 32'(count_o), 1);
            sync();
        end
        drain("t5");

        // Reset while holding with 3 words queued; held and queued words discarded
        do_reset();
        lane_ready_i = 8'h08;
        send(8'h60, 3'd3, 1'b0);
        wait_lvalid(8'h08, "t6_hold_start");
        lane_ready_i = 8'h00;
        send(8'h61, 3'd0, 1'b0);
        send(8'h62, 3'd0, 1'b0);
        send(8'h63, 3'd0, 1'b0);
        for (int n = 0; n < 20 && count_o != 3'd3; n++) sync();
        chk("t6_pre_count", 32'(count_o), 3);
        chk("t6_pre_lvalid", 32'(lane_valid_o), 32'h08);
        do_reset();
        lane_ready_i = 8'hFF;
        send(8'h6A, 3'd0, 1'b1);
        drain("t6");

        repeat (3) sync();
        chk("scoreboard_empty", 32'(expq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/rr_dispatch_8.md
# rr_dispatch_8

Round-robin stream dispatcher that feeds an 8-way demultiplexer stage. It buffers an incoming valid/ready word stream in a small FIFO, picks the next ready output lane in round-robin order, and presents one word at a time as a registered select/data pair plus a one-hot lane valid. The `select_o`/`data_o` outputs connect directly to the downstream demux `select_i`/`data_i`, and the lane valids qualify its eight outputs.

## Interface
- `DATA_WIDTH`, 8: width of data words.
- `FIFO_DEPTH`, 4: input FIFO entries; power of two, ≥2.

Ports:
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `data_i`  in  DATA_WIDTH  input word.
- `valid_i`  in  1  input word valid.
- `ready_o`  out  1  FIFO can accept a word.
- `lane_ready_i`  in  8  per-lane ready from consumers; bit n = lane n.
- `select_o`  out  3  lane index of the held word; drives demux select.
- `data_o`  out  DATA_WIDTH  held word; drives demux data.
- `lane_valid_o`  out  8  one-hot valid for the held word; all zero when nothing is held.
- `count_o`  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.

## Operation
- Reset values:
  - `ready_o`=0 while `rst_i` is high, 1 after release.
  - `select_o`=0, `data_o`=0, `lane_valid_o`=0, `count_o`=0.
  - Round-robin pointer `ptr`=0.
  - FIFO empty, held-word flag clear.
- Input side:
  - Accept when `valid_i && ready_o`.
  - `ready_o` = (count < FIFO_DEPTH), registered/derived from state only. It has no combinational path from `valid_i` or `lane_ready_i`.
- Output stage states:
  - **EMPTY**: no held word; `lane_valid_o`=0.
  - **HOLD**: word held; `lane_valid_o` = one-hot(`select_o`).
- Fire: occurs in HOLD when `lane_ready_i[select_o]`=1; the word is consumed at that edge.
- Load condition (same edge): (EMPTY or fire) and FIFO non-empty and at least one `lane_ready_i` bit set.
- Lane choice on load: the first n scanning `ptr`, `ptr`+1, … mod 8 with `lane_ready_i[n]`=1, using the current cycle's `lane_ready_i`.
- On load:
  - `select_o`←n, `data_o`←FIFO head, FIFO pops.
  - `ptr`←(n+1) mod 8; wrap 7→0.
- No load possible: fire → EMPTY; otherwise the state is unchanged.
- Stability: while in HOLD, `select_o`/`data_o`/`lane_valid_o` stay constant until fire, even if `lane_ready_i[select_o]` drops. A held word is never re-routed.
- In EMPTY, `data_o`/`select_o` keep their last values; consumers qualify with `lane_valid_o`.
- FIFO: circular buffer, read/write pointers wrap at FIFO_DEPTH.
  - Simultaneous push and pop: count unchanged.
  - Push when full cannot occur (`ready_o`=0).
  - Pop when empty cannot occur (load requires non-empty).
  - No bypass: a word written at edge k is loadable at edge k+1 at the earliest.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). FIFO contents and the held word are discarded.

## Timing
- Latency: word accepted at edge k → `lane_valid_o` high after edge k+1 at the earliest (lanes ready).
- Throughput: one word per cycle sustained when ≥1 lane is ready every cycle. Back-to-back fire+load in the same cycle gives no bubble.
- `count_o` and `ready_o` reflect push/pop results after each edge.
- Full FIFO of depth D plus held word: D+1 words buffered total.

## Test plan
- Reset release, all lanes ready, 8 words 0x10..0x17 streamed:
  - First `lane_valid_o`=8'h01 one cycle after the first accept.
  - Words appear on lanes 0..7 in order, one per cycle.
  - After the last fire, `count_o`=0 and `lane_valid_o`=0.
- `lane_ready_i`=8'b0010_0100, 4 words A,B,C,D:
  - Lanes used are 2,5,2,5 in sequence; `ptr` skips non-ready lanes.
- Lane 3 held word with `lane_ready_i[3]` low for 10 cycles while other lanes are ready:
  - `select_o`=3 and `data_o` stay constant for all 10 cycles.
  - FIFO fills to 4 and `ready_o`=0; `valid_i` stays high with no word lost.
  - On lane 3 ready, the words drain in order.
- `lane_ready_i`=0 while 5 words are pushed:
  - 4 accepted; `count_o`=4; `ready_o`=0; `lane_valid_o`=0.
  - Raising all lane readies drains them with `ready_o`=1 after the first pop.
- Continuous input and output at full rate for 100 cycles:
  - `count_o` stays constant.
  - Every word is delivered exactly once, in order, with the lane sequence 0,1,…,7,0,….
- `rst_i` pulsed while in HOLD with `count_o`=3:
  - All outputs return to reset values during reset.
  - After release the next word goes to lane 0; no stale data appears.
